// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles an MSB-first bit-serial key into a WIDTH-bit word
// and presents it downstream on a valid/ready handshake, flagging protocol violations on ERR.
module serial_word_loader #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    input  logic             BIT_IN,
    input  logic             BIT_VLD,
    output logic [WIDTH-1:0] WORD_OUT,
    output logic             WORD_VLD,
    input  logic             WORD_RDY,
    output logic             BUSY,
    output logic             ERR
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-2:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] shifted;

    // Only WIDTH-1 bits need storing: the final bit goes straight into the output word.
    assign shifted = {sreg_q, BIT_IN};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                state_d = SHIFT;
                sreg_d  = '0;
                cnt_d   = '0;
            end
            SHIFT: if (START) begin
                sreg_d = '0;
                cnt_d  = '0;
                err_d  = 1'b1;
            end else if (BIT_VLD) begin
                sreg_d = shifted[WIDTH-2:0];
                cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = HOLD;
                    word_d  = shifted;
                    vld_d   = 1'b1;
                end
            end
            HOLD: begin
                err_d = BIT_VLD | (START & ~WORD_RDY);
                if (WORD_RDY) begin
                    vld_d   = 1'b0;
                    state_d = START ? SHIFT : IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign WORD_OUT = word_q;
    assign WORD_VLD = vld_q;
    assign BUSY     = (state_q != IDLE);
    assign ERR      = err_q;
endmodule
